// File: rtl/fx_pkg.sv
// ============================================================================
//  Module   : fx_pkg
//  Brief    : Shared types and helpers for the fixed-point vector MAC.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package fx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_FLUSH = 3'd2,
        ST_ROUND = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    localparam logic [1:0] RM_TRUNC         = 2'd0;
    localparam logic [1:0] RM_HALF_UP       = 2'd1;
    localparam logic [1:0] RM_HALF_EVEN     = 2'd2;
    localparam logic [1:0] RM_HALF_EVEN_ALT = 2'd3;

    // Wide enough that KMAX full-precision products can never wrap.
    function automatic int acc_width(input int width, input int kmax);
        return 2 * width + $clog2(kmax);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fx_round_sat.sv
// ============================================================================
//  Module   : fx_round_sat
//  Brief    : Drops FRACTION bits of an accumulator with selectable rounding,
//             then saturates to a WIDTH-bit signed result.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fx_round_sat
    import fx_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int FRACTION = 4,
    parameter int ACC_W    = 20
) (
    input  logic signed [ACC_W-1:0] acc,
    input  logic        [1:0]       mode,
    output logic        [WIDTH-1:0] res,
    output logic                    ovf
);

    // One guard bit above the shifted value so the increment cannot wrap.
    localparam int FW = ACC_W - FRACTION + 1;

    localparam logic        [FRACTION-1:0] c_half = FRACTION'(1) << (FRACTION - 1);
    localparam logic signed [FW-1:0]       c_max  = {{(FW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [FW-1:0]       c_min  = ~c_max;

    logic signed [FW-1:0]       w_floor;
    logic        [FRACTION-1:0] w_frac;
    logic                       w_inc;
    logic signed [FW-1:0]       w_round;

    always_comb begin
        w_floor = {acc[ACC_W-1], acc[ACC_W-1:FRACTION]};
        w_frac  = acc[FRACTION-1:0];
        w_inc   = 1'b0;
        case (mode)
            RM_TRUNC:   w_inc = 1'b0;
            RM_HALF_UP: w_inc = (w_frac >= c_half);
            default:    w_inc = (w_frac > c_half) || ((w_frac == c_half) && w_floor[0]);
        endcase
        w_round = w_floor + {{(FW-1){1'b0}}, w_inc};

        if (w_round > c_max) begin
            res = c_max[WIDTH-1:0];
            ovf = 1'b1;
        end else if (w_round < c_min) begin
            res = c_min[WIDTH-1:0];
            ovf = 1'b1;
        end else begin
            res = w_round[WIDTH-1:0];
            ovf = 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/fx_mac_vec.sv
// ============================================================================
//  Module   : fx_mac_vec
//  Brief    : Multi-lane fixed-point dot-product engine with rounding,
//             saturation and ready/valid handshakes on both sides.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module fx_mac_vec
    import fx_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int FRACTION = 4,
    parameter int LANES    = 4,
    parameter int KMAX     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr_i,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [$clog2(KMAX+1)-1:0]   len_i,
    input  logic [1:0]                  rmode_i,
    input  logic [LANES*WIDTH-1:0]      win,
    input  logic [LANES*WIDTH-1:0]      din,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANES*WIDTH-1:0]      acc_o,
    output logic [LANES-1:0]            ovf_o
);

    localparam int LW   = $clog2(KMAX + 1);
    localparam int ACCW = acc_width(WIDTH, KMAX);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [LW-1:0]  r_cnt;
    logic [LW-1:0]  r_len;
    logic [1:0]     r_mode;
    logic           r_prod_vld;

    logic           w_accept;
    logic           w_first;
    logic           w_last;
    logic [LW-1:0]  w_eff_len;
    logic [LW-1:0]  w_cnt_nxt;

    assign w_accept  = in_valid & in_ready;
    assign w_first   = w_accept & (r_state == ST_IDLE);
    assign w_eff_len = (len_i == '0) ? LW'(KMAX) : len_i;
    assign w_cnt_nxt = r_cnt + LW'(1);
    assign w_last    = (r_state == ST_IDLE) ? (w_eff_len == LW'(1)) : (w_cnt_nxt == r_len);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept) w_state_nxt = w_last ? ST_FLUSH : ST_ACCUM;
            ST_ACCUM: if (w_accept && w_last) w_state_nxt = ST_FLUSH;
            ST_FLUSH: w_state_nxt = ST_ROUND;
            ST_ROUND: w_state_nxt = ST_OUT;
            ST_OUT:   if (out_ready) w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
        if (clr_i) w_state_nxt = ST_IDLE;
    end

    always_comb begin
        in_ready  = (r_state == ST_IDLE) || (r_state == ST_ACCUM);
        out_valid = (r_state == ST_OUT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_len      <= '0;
            r_mode     <= RM_TRUNC;
            r_prod_vld <= 1'b0;
        end else if (clr_i) begin
            r_cnt      <= '0;
            r_prod_vld <= 1'b0;
        end else begin
            r_prod_vld <= w_accept;
            if (w_first) begin
                r_cnt  <= LW'(1);
                r_len  <= w_eff_len;
                r_mode <= rmode_i;
            end else if (w_accept) begin
                r_cnt  <= w_cnt_nxt;
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic signed [2*WIDTH-1:0] w_a;
        logic signed [2*WIDTH-1:0] w_b;
        logic signed [2*WIDTH-1:0] r_prod;
        logic signed [ACCW-1:0]    r_acc;
        logic        [WIDTH-1:0]   w_res;
        logic        [WIDTH-1:0]   r_res;
        logic                      w_ovf;
        logic                      r_ovf;

        assign w_a = {{WIDTH{win[i*WIDTH+WIDTH-1]}}, win[i*WIDTH +: WIDTH]};
        assign w_b = {{WIDTH{din[i*WIDTH+WIDTH-1]}}, din[i*WIDTH +: WIDTH]};

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_prod <= '0;
                r_acc  <= '0;
                r_res  <= '0;
                r_ovf  <= 1'b0;
            end else if (clr_i) begin
                r_acc  <= '0;
            end else begin
                if (w_accept) r_prod <= w_a * w_b;
                // The first beat's product is still in flight, so clearing here is safe.
                if (w_first) begin
                    r_acc <= '0;
                end else if (r_prod_vld) begin
                    r_acc <= r_acc + {{(ACCW-2*WIDTH){r_prod[2*WIDTH-1]}}, r_prod};
                end
                if (r_state == ST_ROUND) begin
                    r_res <= w_res;
                    r_ovf <= w_ovf;
                end
            end
        end

        fx_round_sat #(
            .WIDTH    (WIDTH),
            .FRACTION (FRACTION),
            .ACC_W    (ACCW)
        ) u_round_sat (
            .acc  (r_acc),
            .mode (r_mode),
            .res  (w_res),
            .ovf  (w_ovf)
        );

        assign acc_o[i*WIDTH +: WIDTH] = r_res;
        assign ovf_o[i]                = r_ovf;
    end

endmodule

`default_nettype wire

// File: tb/tb_fx_mac_vec.sv
// ============================================================================
//  Module   : tb_fx_mac_vec
//  Brief    : Directed-vector bench for fx_mac_vec (8-bit, Q4, 4 lanes).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fx_mac_vec;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clr_i = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  len_i = '0;
    logic [1:0]  rmode_i = '0;
    logic [31:0] win = '0;
    logic [31:0] din = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] acc_o;
    logic [3:0]  ovf_o;

    int n_vec = 0;
    int n_err = 0;

    fx_mac_vec #(.WIDTH(8), .FRACTION(4), .LANES(4), .KMAX(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (clr_i),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .len_i     (len_i),
        .rmode_i   (rmode_i),
        .win       (win),
        .din       (din),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .acc_o     (acc_o),
        .ovf_o     (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offers n beats back to back; returns at the falling edge after the last accept.
    task automatic send(input int n, input logic [4:0] len, input logic [1:0] rm,
                        input logic [31:0] w, input logic [31:0] d);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1; len_i = len; rmode_i = rm; win = w; din = d;
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 10) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pop(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".drop"}, out_valid, 1'b0);
        chk({tag, ".rdy"}, in_ready, 1'b1);
    endtask

    task automatic run(input string tag, input int n, input logic [4:0] len, input logic [1:0] rm,
                       input logic [31:0] w, input logic [31:0] d,
                       input logic [31:0] e_acc, input logic [3:0] e_ovf);
        int lat;
        send(n, len, rm, w, d);
        wait_out(lat);
        chk({tag, ".lat"}, lat, 3);
        chk({tag, ".acc"}, acc_o, e_acc);
        chk({tag, ".ovf"}, ovf_o, e_ovf);
        pop(tag);
    endtask

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        chk("rst.in_ready", in_ready, 1'b1);
        chk("rst.out_valid", out_valid, 1'b0);
        chk("rst.acc", acc_o, 32'h0);
        chk("rst.ovf", ovf_o, 4'h0);
        rst = 1'b0;

        run("basic", 3, 5'd3, 2'd0, 32'h10101010, 32'h18181818, 32'h48484848, 4'h0);
        run("lanes", 2, 5'd2, 2'd0, 32'h08F02010, 32'h30101010, 32'h30E04020, 4'h0);

        run("rnd0a", 1, 5'd1, 2'd0, 32'h01010101, 32'h08080808, 32'h00000000, 4'h0);
        run("rnd1a", 1, 5'd1, 2'd1, 32'h01010101, 32'h08080808, 32'h01010101, 4'h0);
        run("rnd2a", 1, 5'd1, 2'd2, 32'h01010101, 32'h08080808, 32'h00000000, 4'h0);
        run("rnd0b", 1, 5'd1, 2'd0, 32'h01010101, 32'h18181818, 32'h01010101, 4'h0);
        run("rnd1b", 1, 5'd1, 2'd1, 32'h01010101, 32'h18181818, 32'h02020202, 4'h0);
        run("rnd2b", 1, 5'd1, 2'd2, 32'h01010101, 32'h18181818, 32'h02020202, 4'h0);
        run("rnd3b", 1, 5'd1, 2'd3, 32'h01010101, 32'h18181818, 32'h02020202, 4'h0);

        // Consumer already ready while beats are still arriving.
        out_ready = 1'b1;
        run("satpos", 9, 5'd9, 2'd0, 32'h10101010, 32'h10101010, 32'h7F7F7F7F, 4'hF);
        run("satneg", 16, 5'd16, 2'd0, 32'h80808080, 32'h7F7F7F7F, 32'h80808080, 4'hF);
        run("len0", 16, 5'd0, 2'd0, 32'h01010101, 32'h01010101, 32'h01010101, 4'h0);

        // Backpressure: hold the result while new beats are offered.
        send(3, 5'd3, 2'd0, 32'h10101010, 32'h18181818);
        wait_out(lat);
        chk("bp.lat", lat, 3);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; win = 32'h7F7F7F7F; din = 32'h7F7F7F7F; len_i = 5'd1;
            @(negedge clk);
            chk("bp.valid", out_valid, 1'b1);
            chk("bp.acc", acc_o, 32'h48484848);
            chk("bp.ovf", ovf_o, 4'h0);
            chk("bp.in_ready", in_ready, 1'b0);
        end
        in_valid = 1'b0;
        pop("bp");
        run("bp.next", 1, 5'd1, 2'd0, 32'h10101010, 32'h18181818, 32'h18181818, 4'h0);

        // Abort after 4 of 9 beats.
        send(4, 5'd9, 2'd0, 32'h10101010, 32'h10101010);
        clr_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clr_i = 1'b0;
        chk("clr.in_ready", in_ready, 1'b1);
        chk("clr.out_valid", out_valid, 1'b0);
        repeat (6) @(negedge clk);
        chk("clr.quiet", out_valid, 1'b0);
        run("clr.next", 1, 5'd1, 2'd1, 32'h10101010, 32'h18181818, 32'h18181818, 4'h0);

        // Asynchronous reset while a result is presented.
        send(1, 5'd1, 2'd0, 32'h10101010, 32'h18181818);
        wait_out(lat);
        chk("rout.valid", out_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rout.drop", out_valid, 1'b0);
        chk("rout.acc", acc_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run("rout.next", 3, 5'd3, 2'd0, 32'h10101010, 32'h18181818, 32'h48484848, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fx_mac_vec.md
FX_MAC_VEC -- requirements
Module: fx_mac_vec

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the signed two's-complement bit width of each operand and each result.
REQ-002 SHALL have parameter FRACTION, default 4, meaning the number of fractional bits in operands and results; legal range is 1 to WIDTH-1.
REQ-003 SHALL have parameter LANES, default 4, meaning the number of independent dot-product channels.
REQ-004 SHALL have parameter KMAX, default 16, meaning the maximum number of products per transaction.
REQ-005 SHALL have the following ports, in this order:
  - clk, input, 1 bit: the single clock; all logic is rising-edge.
  - rst, input, 1 bit: reset; asynchronous and active-high.
  - clr_i, input, 1 bit: synchronous abort.
  - in_valid, input, 1 bit: an input beat is offered.
  - in_ready, output, 1 bit: the block accepts a beat.
  - len_i, input, $clog2(KMAX+1) bits: products per transaction; sampled on the first beat only.
  - rmode_i, input, 2 bits: rounding mode; sampled on the first beat only.
  - win, input, LANES*WIDTH bits: weights; lane i occupies [i*WIDTH +: WIDTH].
  - din, input, LANES*WIDTH bits: data, packed the same way as win.
  - out_valid, output, 1 bit: a result is presented.
  - out_ready, input, 1 bit: the consumer accepts the result.
  - acc_o, output, LANES*WIDTH bits: per-lane results, packed the same way as win.
  - ovf_o, output, LANES bits: per-lane saturation flag.

Function
REQ-006 SHALL use a state machine with states IDLE, ACCUM, FLUSH, ROUND and OUT.
REQ-007 SHALL drive in_ready=1 only in IDLE and ACCUM; a beat is accepted on a rising edge where in_valid and in_ready are both 1.
REQ-008 SHALL, on a beat accepted in IDLE, latch len_i (0 is treated as KMAX) and rmode_i, clear the beat counter and accumulators, and go to ACCUM (or to FLUSH if the length is 1).
REQ-009 SHALL register the full-precision 2*WIDTH-bit signed product per lane on every accepted beat, without clipping.
REQ-010 SHALL add each registered product into a per-lane accumulator of width 2*WIDTH+$clog2(KMAX) one cycle after its beat; the accumulator SHALL never wrap.
REQ-011 SHALL leave ACCUM for FLUSH on the edge that accepts the beat completing the latched length, pass FLUSH→ROUND→OUT unconditionally, and load acc_o and ovf_o on the ROUND→OUT edge.
REQ-012 SHALL give a latency where out_valid is 1 immediately after the second rising edge following the edge that accepts the last beat.
REQ-013 SHALL round away the FRACTION lowest accumulator bits according to the latched mode:
  - 0: truncate toward negative infinity;
  - 1: round half up;
  - 2 and 3: round half to even.
REQ-014 SHALL, when the rounded value is outside [-2^(WIDTH-1), 2^(WIDTH-1)-1], clamp that lane to the nearest bound and set its ovf_o bit; otherwise the ovf_o bit is 0.
REQ-015 SHALL hold out_valid, acc_o and ovf_o stable in OUT until out_valid and out_ready are both 1, then go to IDLE; in_ready rises in the following cycle.
REQ-016 SHALL ignore in_valid while in_ready=0.
REQ-017 SHALL, when clr_i=1 on a rising edge, go to IDLE in any state, clear out_valid and discard partial sums; clr_i takes precedence over every other event on that edge.
REQ-018 SHALL, when out_ready=1 and the result is not yet presented, have no effect.

Reset
REQ-019 SHALL, while rst=1, asynchronously force:
  - state IDLE;
  - in_ready=1 from the following cycle, i.e. in_ready=1 once in IDLE;
  - out_valid=0, acc_o=0 and ovf_o=0;
  - beat counter, accumulators and product registers all 0.
REQ-020 SHALL abort any transaction that is in flight when reset is asserted, with no partial output.

Structure
REQ-021 SHALL place the state enumeration, the rounding-mode encodings and the accumulator-width function in the shared package fx_pkg.
REQ-022 SHALL instantiate, once per lane, the combinational sub-module fx_round_sat, which takes accumulator, mode and FRACTION and returns the WIDTH-bit result and the overflow flag.

Verification (WIDTH=8, FRACTION=4, LANES=4, KMAX=16)
REQ-023 SHALL cover the basic sum: len=3, all win=0x10 and din=0x18 → acc_o lanes=0x48 and ovf_o=0, with out_valid two edges after the last beat.
REQ-024 SHALL cover the rounding modes:
  - len=1, win=0x01, din=0x08 → acc_o=0x00, 0x01 and 0x00 for rmode 0, 1 and 2;
  - din=0x18 instead → acc_o=0x01, 0x02 and 0x02.
REQ-025 SHALL cover saturation:
  - len=9, win=din=0x10 → acc_o=0x7F and ovf_o=1;
  - len=16, win=0x80, din=0x7F → acc_o=0x80 and ovf_o=1.
REQ-026 SHALL cover backpressure: out_ready=0 for 5 cycles with in_valid=1 → acc_o, ovf_o and out_valid stay unchanged, in_ready=0 and no beat is consumed.
REQ-027 SHALL cover abort: clr_i pulsed after 4 of 9 beats → IDLE next cycle with no out_valid; a following len=1 transaction produces the correct result.
REQ-028 SHALL cover reset in OUT: rst asserted in OUT → out_valid drops without waiting for a clock edge, and the next transaction is correct.
